// File: rtl/gaxi_skid_pkg.sv
// Shared constants and helpers for the flexible-depth GAXI skid buffer.
// Optional zero-latency bypass is selected by the GAXI_SKID_BYPASS_EN macro.
package gaxi_skid_pkg;

   localparam int MIN_DEPTH = 2;
   localparam int MAX_DEPTH = 16;

   // Explicit compare-and-wrap so non-power-of-two depths index correctly.
   function automatic int ptr_inc(input int ptr, input int depth);
      return (ptr >= depth - 1) ? 0 : ptr + 1;
   endfunction

   function automatic int cw_for(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/gaxi_skid_buffer_flex_if.sv
// Valid/ready bundle for both sides of the skid buffer.
// slave is the buffer's view; master is the producer/consumer view.
interface gaxi_skid_buffer_flex_if #(
   parameter int DATA_WIDTH = 32
);

   logic                  wr_valid;
   logic                  wr_ready;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  rd_valid;
   logic                  rd_ready;
   logic [DATA_WIDTH-1:0] rd_data;

   modport slave (
      input  wr_valid, wr_data, rd_ready,
      output wr_ready, rd_valid, rd_data
   );

   modport master (
      output wr_valid, wr_data, rd_ready,
      input  wr_ready, rd_valid, rd_data
   );

endinterface

// File: rtl/gaxi_skid_ptr.sv
// Wrapping pointer 0..DEPTH-1 with synchronous clear and advance enable.
// Clear has priority over enable; reset is synchronous active-high.
module gaxi_skid_ptr
   import gaxi_skid_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clr_i,
   input  logic          en_i,
   output logic [PW-1:0] ptr_o
);

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (clr_i) begin
         ptr_d = '0;
      end else if (en_i) begin
         ptr_d = PW'(ptr_inc(int'(ptr_q), DEPTH));
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/gaxi_skid_buffer_flex.sv
// Circular-buffer valid/ready skid buffer, DEPTH 2..16, with flush and almost_full.
// Define GAXI_SKID_BYPASS_EN for a zero-latency pass-through when empty.
module gaxi_skid_buffer_flex
   import gaxi_skid_pkg::*;
#(
   parameter int  DATA_WIDTH = 32,
   parameter int  DEPTH      = 4,
   parameter int  AF_THRESH  = DEPTH - 1,
   localparam int CW         = cw_for(DEPTH)
) (
   input  logic                    axi_aclk,
   input  logic                    axi_areset,
   input  logic                    flush,
   gaxi_skid_buffer_flex_if.slave  bus,
   output logic [CW-1:0]           count,
   output logic                    almost_full
);

   localparam int PW = $clog2(DEPTH);

   if (DEPTH < MIN_DEPTH || DEPTH > MAX_DEPTH) begin : g_depth_chk
      $error("gaxi_skid_buffer_flex: DEPTH out of range");
   end
   if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_af_chk
      $error("gaxi_skid_buffer_flex: AF_THRESH out of range");
   end

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [CW-1:0]         count_q;
   logic [CW-1:0]         count_d;
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;

   logic open_q;
   logic wr_ready_int;
   logic rd_valid_buf;
   logic pass;
   logic store;
   logic pop;

   // Handshake qualifiers depend only on registered state, flush and reset.
   assign open_q       = !axi_areset && !flush;
   assign wr_ready_int = open_q && (count_q != CW'(DEPTH));
   assign rd_valid_buf = open_q && (count_q != '0);

`ifdef GAXI_SKID_BYPASS_EN
   logic byp_win;
   assign byp_win      = open_q && (count_q == '0);
   assign pass         = byp_win && bus.wr_valid && bus.rd_ready;
   assign bus.rd_valid = rd_valid_buf || (byp_win && bus.wr_valid);
   assign bus.rd_data  = byp_win ? bus.wr_data : mem_q[rd_ptr];
`else
   assign pass         = 1'b0;
   assign bus.rd_valid = rd_valid_buf;
   assign bus.rd_data  = mem_q[rd_ptr];
`endif

   assign bus.wr_ready = wr_ready_int;
   assign store        = bus.wr_valid && wr_ready_int && !pass;
   assign pop          = rd_valid_buf && bus.rd_ready;

   always_comb begin
      count_d = count_q;
      if (flush) begin
         count_d = '0;
      end else begin
         case ({store, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge axi_aclk) begin
      if (axi_areset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Storage is deliberately left unreset; count gates every read of it.
   always_ff @(posedge axi_aclk) begin
      if (store) begin
         mem_q[wr_ptr] <= bus.wr_data;
      end
   end

   gaxi_skid_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
      .clk_i (axi_aclk),
      .rst_i (axi_areset),
      .clr_i (flush),
      .en_i  (store),
      .ptr_o (wr_ptr)
   );

   gaxi_skid_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
      .clk_i (axi_aclk),
      .rst_i (axi_areset),
      .clr_i (flush),
      .en_i  (pop),
      .ptr_o (rd_ptr)
   );

   assign count       = count_q;
   assign almost_full = (count_q >= CW'(AF_THRESH));

   a_count_range: assert property (@(posedge axi_aclk) disable iff (axi_areset)
      count_q <= CW'(DEPTH));

endmodule
